// File: rtl/branch_target_buffer_if.sv
// Branch target buffer bus: fetch-stage lookup, EX-stage resolution and
// the two statistics counters.
//   master : pipeline side (drives PCs and resolved branch info)
//   slave  : predictor side (returns prediction and counters)
interface branch_target_buffer_if;
  logic [31:0] PC_IF;
  logic        predict_taken_IF;
  logic [31:0] predict_target_IF;
  logic        br_EX;
  logic        stall_EX;
  logic [31:0] PC_EX;
  logic        br_taken_EX;
  logic [31:0] br_target_EX;
  logic        predict_taken_EX;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output PC_IF, br_EX, stall_EX, PC_EX, br_taken_EX, br_target_EX, predict_taken_EX,
    input  predict_taken_IF, predict_target_IF, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  PC_IF, br_EX, stall_EX, PC_EX, br_taken_EX, br_target_EX, predict_taken_EX,
    output predict_taken_IF, predict_target_IF, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : branch_target_buffer_if.slave
//     PC_IF -> predict_taken_IF / predict_target_IF (combinational lookup)
//     br_EX, stall_EX, PC_EX, br_taken_EX, br_target_EX, predict_taken_EX
//              -> table update and branch/mispredict statistics
module branch_target_buffer #(
  parameter int unsigned ENTRY_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_target_buffer_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ENTRY_BITS;
  localparam int unsigned TAG_W = 30 - ENTRY_BITS;

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [31:0]       target_q [DEPTH];
  logic [1:0]        ctr_q    [DEPTH];

  logic [31:0]       branch_cnt_q, branch_cnt_d;
  logic [31:0]       mispredict_cnt_q, mispredict_cnt_d;

  logic [ENTRY_BITS-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0]      tag_if, tag_ex;
  logic                  hit_if, hit_ex, upd;

  // Byte-offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.PC_IF[1:0], bus.PC_EX[1:0]};

  assign idx_if = bus.PC_IF[ENTRY_BITS+1:2];
  assign tag_if = bus.PC_IF[31:ENTRY_BITS+2];
  assign idx_ex = bus.PC_EX[ENTRY_BITS+1:2];
  assign tag_ex = bus.PC_EX[31:ENTRY_BITS+2];

  assign upd = bus.br_EX && !bus.stall_EX;

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is not visible until after the edge.
  always_comb begin
    hit_if = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
    bus.predict_taken_IF  = hit_if && ctr_q[idx_if][1];
    bus.predict_target_IF = bus.predict_taken_IF ? target_q[idx_if] : bus.PC_IF + 32'd4;
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (upd) begin
      if (branch_cnt_q != '1)
        branch_cnt_d = branch_cnt_q + 32'd1;
      if ((bus.br_taken_EX != bus.predict_taken_EX) && (mispredict_cnt_q != '1))
        mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      if (upd) begin
        if (hit_ex) begin
          if (bus.br_taken_EX) begin
            if (ctr_q[idx_ex] != 2'b11)
              ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'd1;
            target_q[idx_ex] <= bus.br_target_EX;
          end else if (ctr_q[idx_ex] != 2'b00) begin
            ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'd1;
          end
        end else if (bus.br_taken_EX) begin
          // Miss on a taken branch replaces whatever occupies the slot.
          valid_q[idx_ex]  <= 1'b1;
          tag_q[idx_ex]    <= tag_ex;
          target_q[idx_ex] <= bus.br_target_EX;
          ctr_q[idx_ex]    <= 2'b10;
        end
      end
    end
  end

  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRY_BITS = 4): expected
// lookup results and counter values are queued as each step is driven and
// checked once the DUT outputs have settled.
module tb_branch_target_buffer;

  logic clk;
  logic rst_n;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRY_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_bc = 0;
  logic [31:0] exp_mc = 0;

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 entries exp 1");
      return;
    end
    e = sbq.pop_front();
    checks++;
    assert (bus.predict_taken_IF === e.pt) else begin
      errors++;
      $error("FAIL %s taken got %0b exp %0b", e.tag, bus.predict_taken_IF, e.pt);
    end
    checks++;
    assert (bus.predict_target_IF === e.tgt) else begin
      errors++;
      $error("FAIL %s target got %h exp %h", e.tag, bus.predict_target_IF, e.tgt);
    end
    checks++;
    assert (bus.branch_cnt === e.bc) else begin
      errors++;
      $error("FAIL %s branch_cnt got %0d exp %0d", e.tag, bus.branch_cnt, e.bc);
    end
    checks++;
    assert (bus.mispredict_cnt === e.mc) else begin
      errors++;
      $error("FAIL %s mispredict_cnt got %0d exp %0d", e.tag, bus.mispredict_cnt, e.mc);
    end
  endtask

  task automatic expect_lookup(input string tag, input logic [31:0] pc,
                               input logic pt, input logic [31:0] tgt);
    bus.PC_IF = pc;
    sbq.push_back('{tag, pt, tgt, exp_bc, exp_mc});
    #1;
    check_out();
  endtask

  task automatic ex_idle();
    bus.br_EX            = 1'b0;
    bus.stall_EX         = 1'b0;
    bus.PC_EX            = 32'h0;
    bus.br_taken_EX      = 1'b0;
    bus.br_target_EX     = 32'h0;
    bus.predict_taken_EX = 1'b0;
  endtask

  task automatic ex_drive(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic pred);
    bus.br_EX            = 1'b1;
    bus.stall_EX         = 1'b0;
    bus.PC_EX            = pc;
    bus.br_taken_EX      = taken;
    bus.br_target_EX     = tgt;
    bus.predict_taken_EX = pred;
  endtask

  // One accepted update on the next rising edge.
  task automatic resolve(input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic pred);
    ex_drive(pc, taken, tgt, pred);
    @(posedge clk);
    #1;
    ex_idle();
    exp_bc = exp_bc + 1;
    if (taken != pred) exp_mc = exp_mc + 1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_idle();
    bus.PC_IF = 32'h100;

    // Reset state, with a branch presented while reset is held.
    expect_lookup("reset", 32'h100, 1'b0, 32'h104);
    ex_drive(32'h100, 1'b1, 32'h200, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    ex_idle();
    expect_lookup("reset_no_update", 32'h100, 1'b0, 32'h104);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Allocate, then walk the counter up, saturate, and back down.
    resolve(32'h100, 1'b1, 32'h200, 1'b0);
    expect_lookup("alloc", 32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b1, 32'h200, 1'b1);
    resolve(32'h100, 1'b1, 32'h200, 1'b1);
    expect_lookup("ctr11", 32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b0, 32'h0, 1'b1);
    expect_lookup("ctr10", 32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b0, 32'h0, 1'b1);
    expect_lookup("ctr01", 32'h100, 1'b0, 32'h104);
    resolve(32'h100, 1'b0, 32'h0, 1'b0);
    resolve(32'h100, 1'b0, 32'h0, 1'b0);
    expect_lookup("ctr00_sat", 32'h100, 1'b0, 32'h104);
    // Hit on a weak entry increments rather than re-allocating at 10.
    resolve(32'h100, 1'b1, 32'h300, 1'b0);
    expect_lookup("hit_inc_01", 32'h100, 1'b0, 32'h104);
    resolve(32'h100, 1'b1, 32'h300, 1'b0);
    expect_lookup("target_overwrite", 32'h100, 1'b1, 32'h300);

    // Miss and not taken leaves the table alone.
    resolve(32'h184, 1'b0, 32'h900, 1'b0);
    expect_lookup("miss_not_taken", 32'h184, 1'b0, 32'h188);

    // Aliasing branch at the same index evicts the old one.
    resolve(32'h140, 1'b1, 32'h400, 1'b0);
    expect_lookup("replace_new", 32'h140, 1'b1, 32'h400);
    expect_lookup("replace_old", 32'h100, 1'b0, 32'h104);
    expect_lookup("offset_ignored", 32'h142, 1'b1, 32'h400);

    // Stalled branch: three held cycles, then one release.
    ex_drive(32'h184, 1'b1, 32'h500, 1'b0);
    bus.stall_EX = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_lookup("stall_held", 32'h184, 1'b0, 32'h188);
    bus.stall_EX = 1'b0;
    @(posedge clk);
    #1;
    ex_idle();
    exp_bc = exp_bc + 1;
    exp_mc = exp_mc + 1;
    expect_lookup("stall_release", 32'h184, 1'b1, 32'h500);

    // Same-index lookup during an update sees the old entry.
    ex_drive(32'h184, 1'b0, 32'h0, 1'b1);
    expect_lookup("no_bypass", 32'h184, 1'b1, 32'h500);
    @(posedge clk);
    #1;
    ex_idle();
    exp_bc = exp_bc + 1;
    exp_mc = exp_mc + 1;
    expect_lookup("after_same_cycle", 32'h184, 1'b0, 32'h188);

    expect_lookup("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Flushed EX slot has no effect.
    bus.br_taken_EX  = 1'b1;
    bus.br_target_EX = 32'h700;
    @(posedge clk);
    #1;
    ex_idle();
    expect_lookup("flush_slot", 32'h0, 1'b0, 32'h4);

    // Asynchronous reset between edges, then held through an offered branch.
    #2;
    rst_n = 1'b0;
    exp_bc = 0;
    exp_mc = 0;
    expect_lookup("async_reset", 32'h140, 1'b0, 32'h144);
    ex_drive(32'h140, 1'b1, 32'h600, 1'b0);
    @(posedge clk);
    #1;
    expect_lookup("reset_discard", 32'h140, 1'b0, 32'h144);
    ex_idle();
    #2;
    rst_n = 1'b1;
    resolve(32'h140, 1'b1, 32'h600, 1'b0);
    expect_lookup("first_after_reset", 32'h140, 1'b1, 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
